// File: rtl/l2wcfifo.sv
// Write-combining request queue between the dcache and the L2. Word requests
// are buffered in order; a write to the newest queued write's word is merged.
module l2wcfifo #(
  parameter int DEPTH    = 8,
  parameter int MERGE_EN = 1,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dcache_l2fifo_req,
  input  logic [31:2]   dcache_l2fifo_addr,
  input  logic          dcache_l2fifo_wen,
  input  logic [3:0]    dcache_l2fifo_wmask,
  input  logic [31:0]   dcache_l2fifo_wdata,
  output logic          l2fifo_dc_ready,
  output logic          l2fifo_l2_req,
  output logic [31:2]   l2fifo_l2_addr,
  output logic          l2fifo_l2_wen,
  output logic [3:0]    l2fifo_l2_wmask,
  output logic [31:0]   l2fifo_l2_wdata,
  input  logic          l2_l2fifo_ready,
  output logic [CW-1:0] l2fifo_count,
  output logic          l2fifo_empty
);

  localparam int AW = $clog2(DEPTH);

  // Entry storage, split per field; deliberately not reset.
  logic [31:2]   addr_mem  [DEPTH];
  logic          wen_mem   [DEPTH];
  logic [3:0]    wmask_mem [DEPTH];
  logic [31:0]   wdata_mem [DEPTH];

  logic [AW-1:0] head_reg;
  logic [AW-1:0] tail_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  logic [AW-1:0] newest_idx;
  logic          full;
  logic          pop;
  logic          merge_hit;
  logic          accept;
  logic          do_merge;
  logic          do_alloc;
  logic [3:0]    merged_mask;
  logic [31:0]   merged_data;

  assign newest_idx = tail_reg - AW'(1);
  assign full       = (count_reg == CW'(DEPTH));

  // Head side is purely registered state: no path from the dcache inputs.
  assign l2fifo_l2_req   = (count_reg != '0);
  assign l2fifo_l2_addr  = addr_mem[head_reg];
  assign l2fifo_l2_wen   = wen_mem[head_reg];
  assign l2fifo_l2_wmask = wmask_mem[head_reg];
  assign l2fifo_l2_wdata = wdata_mem[head_reg];
  assign l2fifo_count    = count_reg;
  assign l2fifo_empty    = (count_reg == '0);

  assign pop = l2fifo_l2_req & l2_l2fifo_ready;

  // Merging into an entry that leaves this cycle would lose the new bytes,
  // so the single-entry pop case falls back to a fresh allocation.
  always_comb begin
    merge_hit = 1'b0;
    if ((MERGE_EN != 0) && dcache_l2fifo_req && dcache_l2fifo_wen && (count_reg != '0)) begin
      merge_hit = wen_mem[newest_idx]
                  && (addr_mem[newest_idx] == dcache_l2fifo_addr)
                  && !((count_reg == CW'(1)) && pop);
    end
  end

  assign l2fifo_dc_ready = ~full | merge_hit;
  assign accept          = dcache_l2fifo_req & l2fifo_dc_ready & ~rst;
  assign do_merge        = accept & merge_hit;
  assign do_alloc        = accept & ~merge_hit;

  assign merged_mask = wmask_mem[newest_idx] | dcache_l2fifo_wmask;

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    assign merged_data[8*gi +: 8] = dcache_l2fifo_wmask[gi] ? dcache_l2fifo_wdata[8*gi +: 8]
                                                            : wdata_mem[newest_idx][8*gi +: 8];
  end

  always_ff @(posedge clk) begin
    if (do_merge) begin
      wmask_mem[newest_idx] <= merged_mask;
      wdata_mem[newest_idx] <= merged_data;
    end else if (do_alloc) begin
      addr_mem[tail_reg]  <= dcache_l2fifo_addr;
      wen_mem[tail_reg]   <= dcache_l2fifo_wen;
      wmask_mem[tail_reg] <= dcache_l2fifo_wmask;
      wdata_mem[tail_reg] <= dcache_l2fifo_wdata;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({do_alloc, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (pop)      head_reg <= head_reg + AW'(1);
      if (do_alloc) tail_reg <= tail_reg + AW'(1);
      count_reg <= count_next;
    end
  end

endmodule

// File: tb/tb_l2wcfifo.sv
// Bench for l2wcfifo: three instances (8/merge, 4/merge, 8/no-merge) share
// stimulus; each is compared every cycle against a queue-based model.
module tb_l2wcfifo;

  typedef struct packed {
    logic [29:0] addr;
    logic        wen;
    logic [3:0]  mask;
    logic [31:0] data;
  } entry_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req, wen, l2_ready;
  logic [29:0] addr;
  logic [3:0]  wmask;
  logic [31:0] wdata;

  logic        o_ready [3];
  logic        o_req   [3];
  logic        o_wen   [3];
  logic        o_empty [3];
  logic [29:0] o_addr  [3];
  logic [3:0]  o_mask  [3];
  logic [31:0] o_data  [3];
  logic [3:0]  cnt_a;
  logic [2:0]  cnt_b;
  logic [3:0]  cnt_c;

  int checks = 0;
  int errors = 0;
  entry_t mq0[$];
  entry_t mq1[$];
  entry_t mq2[$];
  int dep[3] = '{8, 4, 8};
  int men[3] = '{1, 1, 0};
  int ord[3] = '{'h10, 'h14, 'h18};

  l2wcfifo #(.DEPTH(8), .MERGE_EN(1)) dut_a (
    .clk(clk), .rst(rst), .dcache_l2fifo_req(req), .dcache_l2fifo_addr(addr),
    .dcache_l2fifo_wen(wen), .dcache_l2fifo_wmask(wmask), .dcache_l2fifo_wdata(wdata),
    .l2fifo_dc_ready(o_ready[0]), .l2fifo_l2_req(o_req[0]), .l2fifo_l2_addr(o_addr[0]),
    .l2fifo_l2_wen(o_wen[0]), .l2fifo_l2_wmask(o_mask[0]), .l2fifo_l2_wdata(o_data[0]),
    .l2_l2fifo_ready(l2_ready), .l2fifo_count(cnt_a), .l2fifo_empty(o_empty[0]));

  l2wcfifo #(.DEPTH(4), .MERGE_EN(1)) dut_b (
    .clk(clk), .rst(rst), .dcache_l2fifo_req(req), .dcache_l2fifo_addr(addr),
    .dcache_l2fifo_wen(wen), .dcache_l2fifo_wmask(wmask), .dcache_l2fifo_wdata(wdata),
    .l2fifo_dc_ready(o_ready[1]), .l2fifo_l2_req(o_req[1]), .l2fifo_l2_addr(o_addr[1]),
    .l2fifo_l2_wen(o_wen[1]), .l2fifo_l2_wmask(o_mask[1]), .l2fifo_l2_wdata(o_data[1]),
    .l2_l2fifo_ready(l2_ready), .l2fifo_count(cnt_b), .l2fifo_empty(o_empty[1]));

  l2wcfifo #(.DEPTH(8), .MERGE_EN(0)) dut_c (
    .clk(clk), .rst(rst), .dcache_l2fifo_req(req), .dcache_l2fifo_addr(addr),
    .dcache_l2fifo_wen(wen), .dcache_l2fifo_wmask(wmask), .dcache_l2fifo_wdata(wdata),
    .l2fifo_dc_ready(o_ready[2]), .l2fifo_l2_req(o_req[2]), .l2fifo_l2_addr(o_addr[2]),
    .l2fifo_l2_wen(o_wen[2]), .l2fifo_l2_wmask(o_mask[2]), .l2fifo_l2_wdata(o_data[2]),
    .l2_l2fifo_ready(l2_ready), .l2fifo_count(cnt_c), .l2fifo_empty(o_empty[2]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour of one instance for the current cycle: compare the
  // outputs, then advance the queue as the rising edge will.
  task automatic model_cycle(input int k);
    entry_t q[$];
    entry_t e;
    bit     exp_req, pop, mhit, exp_rdy;
    int     g_cnt;
    case (k)
      0:       begin q = mq0; g_cnt = int'(cnt_a); end
      1:       begin q = mq1; g_cnt = int'(cnt_b); end
      default: begin q = mq2; g_cnt = int'(cnt_c); end
    endcase
    exp_req = (q.size() != 0);
    pop     = exp_req && l2_ready;
    mhit    = 1'b0;
    if (men[k] != 0 && req && wen && q.size() != 0)
      mhit = q[q.size()-1].wen && (q[q.size()-1].addr == addr) && !(q.size() == 1 && pop);
    exp_rdy = (q.size() < dep[k]) || mhit;

    check($sformatf("%0d.ready", k), 64'(o_ready[k]), 64'(exp_rdy));
    check($sformatf("%0d.req", k),   64'(o_req[k]),   64'(exp_req));
    check($sformatf("%0d.count", k), 64'(g_cnt),      64'(q.size()));
    check($sformatf("%0d.empty", k), 64'(o_empty[k]), 64'(q.size() == 0));
    if (exp_req) begin
      check($sformatf("%0d.addr", k), 64'(o_addr[k]), 64'(q[0].addr));
      check($sformatf("%0d.wen", k),  64'(o_wen[k]),  64'(q[0].wen));
      check($sformatf("%0d.mask", k), 64'(o_mask[k]), 64'(q[0].mask));
      check($sformatf("%0d.data", k), 64'(o_data[k]), 64'(q[0].data));
    end

    if (rst) begin
      q.delete();
    end else begin
      if (req && exp_rdy && mhit) begin
        e = q[q.size()-1];
        for (int b = 0; b < 4; b++)
          if (wmask[b]) e.data[8*b +: 8] = wdata[8*b +: 8];
        e.mask = e.mask | wmask;
        q[q.size()-1] = e;
        if (k == 0) $display("[%0t] merge addr=%h mask=%b data=%h", $time, {addr, 2'b00}, e.mask, e.data);
      end
      if (pop) begin
        if (k == 0) $display("[%0t] pop   addr=%h wen=%b mask=%b data=%h", $time, {q[0].addr, 2'b00}, q[0].wen, q[0].mask, q[0].data);
        void'(q.pop_front());
      end
      if (req && exp_rdy && !mhit) begin
        e.addr = addr; e.wen = wen; e.mask = wmask; e.data = wdata;
        q.push_back(e);
        if (k == 0) $display("[%0t] push  addr=%h wen=%b mask=%b data=%h", $time, {addr, 2'b00}, wen, wmask, wdata);
      end
    end

    case (k)
      0:       mq0 = q;
      1:       mq1 = q;
      default: mq2 = q;
    endcase
  endtask

  // Inputs are driven at the falling edge; checks run 1 ns later.
  task automatic cycle();
    #1;
    for (int k = 0; k < 3; k++) model_cycle(k);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic w, input int byte_addr, input logic [3:0] m, input logic [31:0] d);
    req = 1'b1; wen = w; addr = 30'(byte_addr >> 2); wmask = m; wdata = d;
    cycle();
    req = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    req = 1'b0;
    l2_ready = 1'b1;
    while (!(cnt_a == 0 && cnt_b == 0 && cnt_c == 0) && n < 20) begin
      cycle();
      n++;
    end
    check("drain_done", 64'(cnt_a == 0 && cnt_b == 0 && cnt_c == 0), 64'd1);
    l2_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; req = 1'b0; wen = 1'b0; l2_ready = 1'b0;
    addr = '0; wmask = '0; wdata = '0;
    @(posedge clk);
    @(negedge clk);
    cycle();
    rst = 1'b0;
    #1;
    check("rst.ready", 64'(o_ready[0]), 64'd1);
    check("rst.req",   64'(o_req[0]),   64'd0);
    check("rst.empty", 64'(o_empty[0]), 64'd1);
    check("rst.count", 64'(cnt_a),      64'd0);

    // In-order delivery of reads
    push(1'b0, 'h10, 4'h0, 32'h0);
    push(1'b0, 'h14, 4'h0, 32'h0);
    push(1'b0, 'h18, 4'h0, 32'h0);
    #1;
    check("ord.count", 64'(cnt_a),      64'd3);
    check("ord.empty", 64'(o_empty[0]), 64'd0);
    l2_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("ord.req",  64'(o_req[0]),  64'd1);
      check("ord.addr", 64'(o_addr[0]), 64'(ord[i] >> 2));
      cycle();
    end
    #1;
    check("ord.req_drop", 64'(o_req[0]),   64'd0);
    check("ord.empty_1",  64'(o_empty[0]), 64'd1);
    l2_ready = 1'b0;

    // Byte-wise merge into the newest write
    push(1'b1, 'h40, 4'b0001, 32'h000000AA);
    push(1'b1, 'h40, 4'b0100, 32'h00BB0000);
    #1;
    check("mrg.count",   64'(cnt_a),     64'd1);
    check("mrg.mask",    64'(o_mask[0]), 64'b0101);
    check("mrg.data",    64'(o_data[0]), 64'h00BB00AA);
    check("mrg.nomerge", 64'(cnt_c),     64'd2);
    drain();

    // A read between writes blocks merging
    push(1'b1, 'h40, 4'hF, 32'h1);
    push(1'b0, 'h40, 4'h0, 32'h0);
    push(1'b1, 'h40, 4'hF, 32'h2);
    #1;
    check("rd.count", 64'(cnt_a), 64'd3);
    drain();

    // Full behaviour
    for (int i = 0; i < 8; i++) push(1'b1, 'h100 + 4*i, 4'hF, 32'(i));
    req = 1'b1; wen = 1'b1; addr = 30'('h200 >> 2); wmask = 4'hF; wdata = 32'hDEAD;
    #1;
    check("full.ready_new", 64'(o_ready[0]), 64'd0);
    addr = 30'('h11C >> 2);
    #1;
    check("full.ready_merge", 64'(o_ready[0]), 64'd1);
    cycle();
    #1;
    check("full.count_merge", 64'(cnt_a), 64'd8);
    addr = 30'('h200 >> 2);
    l2_ready = 1'b1;
    #1;
    check("full.ready_pop", 64'(o_ready[0]), 64'd0);
    cycle();
    req = 1'b0; l2_ready = 1'b0;
    #1;
    check("full.count_pop", 64'(cnt_a), 64'd7);
    drain();

    // Single entry being popped must not absorb a new write
    push(1'b1, 'h80, 4'hF, 32'h11111111);
    l2_ready = 1'b1;
    req = 1'b1; wen = 1'b1; addr = 30'('h80 >> 2); wmask = 4'hF; wdata = 32'h22222222;
    #1;
    check("race.ready", 64'(o_ready[0]), 64'd1);
    check("race.old",   64'(o_data[0]),  64'h11111111);
    cycle();
    req = 1'b0; l2_ready = 1'b0;
    #1;
    check("race.count", 64'(cnt_a),     64'd1);
    check("race.new",   64'(o_data[0]), 64'h22222222);
    drain();

    // Randomized traffic with stalls, a small address pool and rare resets
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 99) == 0);
      req      = ($urandom_range(0, 3) != 0);
      wen      = $urandom_range(0, 1) == 1;
      addr     = 30'(('h40 + 4 * $urandom_range(0, 3)) >> 2);
      wmask    = 4'($urandom);
      wdata    = $urandom;
      l2_ready = ($urandom_range(0, 2) == 0);
      cycle();
      check("rnd.b_le4", 64'(cnt_b <= 3'd4), 64'd1);
    end
    rst = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
